// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler
//   Round-robin time-division scheduler for the 1-to-8 demux datapath.
//   One valid/ready input stream is routed to one of 8 registered output
//   channels. Enabled channels are visited in round-robin order; each visit
//   (slot) lasts `dwell` accepted beats, with one SCAN bubble between slots.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, stop       control pulses (stop lets the current slot finish)
//   en_mask[7:0]      channel enables, sampled once per slot in SCAN
//   dwell[CW-1:0]     beats per slot, 0 behaves as 1
//   a_valid/a_ready   input handshake, a_data[DW-1:0] input beat
//   s[2:0]            current channel select
//   y[8*DW-1:0]       channel outputs, channel i at [i*DW +: DW]
//   y_valid[7:0]      per-channel update strobe (cycle after acceptance)
//   busy, slot_done   not-IDLE flag, final-beat-accepted pulse

// One output channel: data register plus update strobe.
module demux_rr_lane #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y,
  output logic          v
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
      v <= 1'b0;
    end else begin
      v <= wr;
      if (wr) y <= d;
    end
  end
endmodule

module demux_rr_scheduler #(
  parameter int DW = 1,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [7:0]      en_mask,
  input  logic [CW-1:0]   dwell,
  input  logic            a_valid,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  output logic [2:0]      s,
  output logic [8*DW-1:0] y,
  output logic [7:0]      y_valid,
  output logic            busy,
  output logic            slot_done
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, SCAN, ROUTE} state_t;

  state_t        state, state_nx;
  logic [2:0]    ptr;
  logic          stop_pend;
  logic [CW-1:0] cnt;
  logic [2:0]    pick;
  logic          acc, last;

  logic [NUM_LANES-1:0][DW-1:0] y_arr;
  logic [NUM_LANES-1:0]         lane_wr;

  assign a_ready   = (state == ROUTE);
  assign busy      = (state != IDLE);
  assign acc       = a_valid && a_ready;
  assign last      = acc && (cnt == CW'(1));
  assign slot_done = last;

  // First enabled channel at or after ptr, wrapping 7->0. Walking the
  // offsets from far to near lets the nearest hit overwrite the others.
  always_comb begin
    pick = ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (en_mask[3'(ptr + 3'(k))]) pick = 3'(ptr + 3'(k));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (en_mask != 8'd0)) state_nx = SCAN;
      SCAN:    state_nx = (stop_pend || (en_mask == 8'd0)) ? IDLE : ROUTE;
      ROUTE:   if (last) state_nx = (stop_pend || stop) ? IDLE : SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      stop_pend <= 1'b0;
      cnt       <= '0;
      s         <= 3'd0;
    end else begin
      state <= state_nx;
      // stop is only remembered once scheduling is running; any entry to
      // IDLE consumes it.
      if (state_nx == IDLE)                  stop_pend <= 1'b0;
      else if (stop && (state != IDLE))      stop_pend <= 1'b1;
      if ((state == SCAN) && (state_nx == ROUTE)) begin
        s   <= pick;
        cnt <= (dwell == '0) ? CW'(1) : dwell;
      end else if (acc) begin
        cnt <= cnt - CW'(1);
      end
      if (last) ptr <= s + 3'd1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_wr[i] = acc && (s == 3'(i));
    demux_rr_lane #(.DW(DW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (lane_wr[i]),
      .d     (a_data),
      .y     (y_arr[i]),
      .v     (y_valid[i])
    );
  end

  assign y = y_arr;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
module tb_demux_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic [7:0] en_mask = 8'd0;
  logic [3:0] dwell = 4'd0;
  logic       a_valid = 1'b0;
  logic [0:0] a_data = 1'b0;
  logic       a_ready;
  logic [2:0] s;
  logic [7:0] y;
  logic [7:0] y_valid;
  logic       busy, slot_done;

  int checks = 0;
  int errs = 0;

  demux_rr_scheduler #(.DW(1), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en_mask(en_mask),
    .dwell(dwell), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .s(s), .y(y), .y_valid(y_valid), .busy(busy), .slot_done(slot_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; a_valid = 0; a_data = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  // start pulse, SCAN cycle, land in the first ROUTE cycle
  task automatic kick();
    start = 1; tick(); start = 0; tick();
  endtask

  task automatic test_reset();
    en_mask = 8'hFF; dwell = 4'd2;
    rst_n = 0; #3;
    checks++; if ({s, y, y_valid, a_ready, busy, slot_done} !== 22'd0) begin
      errs++; $display("FAIL reset_outputs got=%h want=0", {s, y, y_valid, a_ready, busy, slot_done});
    end
    do_reset();
  endtask

  task automatic test_full_rotation();
    en_mask = 8'hFF; dwell = 4'd2; a_valid = 1;
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b1 || a_ready !== 1'b0) begin
      errs++; $display("FAIL rot_scan busy=%b a_ready=%b want 1/0", busy, a_ready);
    end
    tick();
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < 2; b++) begin
        a_data = (b == 0) ? 1'b1 : 1'b0;
        checks++; if (s !== 3'(c) || a_ready !== 1'b1 || slot_done !== (b == 1)) begin
          errs++; $display("FAIL rot_beat c=%0d b=%0d s=%0d rdy=%b done=%b", c, b, s, a_ready, slot_done);
        end
        tick();
        checks++; if (y_valid !== (8'd1 << c) || y[c] !== a_data) begin
          errs++; $display("FAIL rot_yv c=%0d b=%0d y_valid=%b y=%b", c, b, y_valid, y);
        end
      end
      checks++; if (a_ready !== 1'b0 || slot_done !== 1'b0 || busy !== 1'b1) begin
        errs++; $display("FAIL rot_bubble c=%0d rdy=%b done=%b busy=%b want 0/0/1", c, a_ready, slot_done, busy);
      end
      tick();
    end
    checks++; if (s !== 3'd0 || a_ready !== 1'b1 || y_valid !== 8'd0) begin
      errs++; $display("FAIL rot_wrap s=%0d rdy=%b yv=%b want 0/1/0", s, a_ready, y_valid);
    end
    do_reset();
  endtask

  task automatic run_single_beat_slots(input logic [7:0] m, input logic [3:0] dw,
                                       input logic [2:0] seq [5], input int n, input string nm);
    en_mask = m; dwell = dw; a_valid = 1; a_data = 1;
    kick();
    for (int i = 0; i < n; i++) begin
      checks++; if (s !== seq[i] || a_ready !== 1'b1 || slot_done !== 1'b1) begin
        errs++; $display("FAIL %s_slot i=%0d s=%0d want %0d rdy=%b done=%b", nm, i, s, seq[i], a_ready, slot_done);
      end
      tick();
      checks++; if (y_valid !== (8'd1 << seq[i])) begin
        errs++; $display("FAIL %s_yv i=%0d got=%b want=%b", nm, i, y_valid, 8'd1 << seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_sparse_mask();
    logic [2:0] seq [5] = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
    run_single_beat_slots(8'b1010_0100, 4'd1, seq, 5, "sparse");
    checks++; if ((y & 8'b0101_1011) !== 8'd0) begin
      errs++; $display("FAIL sparse_disabled y=%b want disabled channels 0", y);
    end
    do_reset();
  endtask

  task automatic test_dwell_limits();
    logic [2:0] seq [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    int beats, cycles;
    bit done, seen;
    run_single_beat_slots(8'b0000_0011, 4'd0, seq, 3, "dwell0");
    do_reset();
    en_mask = 8'b0000_0001; dwell = 4'd15;
    kick();
    beats = 0; cycles = 0; seen = 0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      a_valid = (cyc % 2 == 0);
      #1;
      if (a_valid && a_ready) beats++;
      done = slot_done;
      tick();
      cycles = cyc + 1;
      if (done) seen = 1;
    end
    a_valid = 0;
    checks++; if (!seen || beats != 15 || cycles != 29) begin
      errs++; $display("FAIL dwell15 seen=%0d beats=%0d cycles=%0d want 1/15/29", seen, beats, cycles);
    end
    checks++; if (a_ready !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL dwell15_after rdy=%b busy=%b want 0/1", a_ready, busy);
    end
    do_reset();
  endtask

  task automatic test_stop();
    en_mask = 8'b0000_1000; dwell = 4'd4;
    kick();
    checks++; if (s !== 3'd3 || a_ready !== 1'b1) begin
      errs++; $display("FAIL stop_entry s=%0d rdy=%b want 3/1", s, a_ready);
    end
    a_valid = 1; tick();
    stop = 1; tick(); stop = 0;
    tick();
    checks++; if (slot_done !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL stop_last done=%b busy=%b want 1/1", slot_done, busy);
    end
    tick(); a_valid = 0;
    checks++; if (busy !== 1'b0 || a_ready !== 1'b0) begin
      errs++; $display("FAIL stop_idle busy=%b rdy=%b want 0/0", busy, a_ready);
    end
    en_mask = 8'd0; start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b0) begin
      errs++; $display("FAIL start_mask0 busy=%b want 0", busy);
    end
    en_mask = 8'b0000_1000; start = 1; stop = 1; tick(); start = 0; stop = 0;
    checks++; if (busy !== 1'b1) begin
      errs++; $display("FAIL start_stop busy=%b want 1", busy);
    end
    tick();
    checks++; if (s !== 3'd3 || a_ready !== 1'b1) begin
      errs++; $display("FAIL start_stop_route s=%0d rdy=%b want 3/1", s, a_ready);
    end
    a_valid = 1; repeat (4) tick(); a_valid = 0;
    checks++; if (busy !== 1'b1 || a_ready !== 1'b0) begin
      errs++; $display("FAIL start_stop_rescan busy=%b rdy=%b want 1/0", busy, a_ready);
    end
    do_reset();
  endtask

  task automatic test_mask_drop_and_reset();
    en_mask = 8'h10; dwell = 4'd2;
    kick();
    checks++; if (s !== 3'd4) begin
      errs++; $display("FAIL drop_entry s=%0d want 4", s);
    end
    en_mask = 8'd0; a_valid = 1; tick();
    checks++; if (slot_done !== 1'b1 || a_ready !== 1'b1) begin
      errs++; $display("FAIL drop_complete done=%b rdy=%b want 1/1", slot_done, a_ready);
    end
    tick();
    checks++; if (busy !== 1'b1 || a_ready !== 1'b0) begin
      errs++; $display("FAIL drop_scan busy=%b rdy=%b want 1/0", busy, a_ready);
    end
    a_valid = 0; tick();
    checks++; if (busy !== 1'b0 || s !== 3'd4) begin
      errs++; $display("FAIL drop_idle busy=%b s=%0d want 0/4", busy, s);
    end
    en_mask = 8'hFF; dwell = 4'd3; a_data = 1;
    kick();
    checks++; if (s !== 3'd5) begin
      errs++; $display("FAIL rst_pre s=%0d want 5", s);
    end
    a_valid = 1; tick();
    #2 rst_n = 0; #1;
    checks++; if ({s, y, y_valid, a_ready, busy, slot_done} !== 22'd0) begin
      errs++; $display("FAIL async_reset got=%h want=0", {s, y, y_valid, a_ready, busy, slot_done});
    end
    #2 rst_n = 1; a_valid = 0;
    tick();
    kick();
    checks++; if (s !== 3'd0 || a_ready !== 1'b1 || y !== 8'd0) begin
      errs++; $display("FAIL post_reset s=%0d rdy=%b y=%b want 0/1/0", s, a_ready, y);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_rotation();
    test_sparse_mask();
    test_dwell_limits();
    test_stop();
    test_mask_drop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
